// File: rtl/maxi_req_arbiter_if.sv
// Bundle of the requester-side, memory-request and completion signals around
// the request arbiter. The arbiter uses the "master" view because it masters
// the shared memory-request port. The requesters and controller use the
// "slave" view.
interface maxi_req_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [3*NUM_REQ-1:0]  req_bar_hit;
    logic [32*NUM_REQ-1:0] req_pcie_address;
    logic [4*NUM_REQ-1:0]  req_byte_enable;
    logic [NUM_REQ-1:0]    req_write_readn;
    logic [NUM_REQ-1:0]    req_phys_func;
    logic [32*NUM_REQ-1:0] req_write_data;

    logic                  mem_req_valid;
    logic [2:0]            mem_req_bar_hit;
    logic [31:0]           mem_req_pcie_address;
    logic [3:0]            mem_req_byte_enable;
    logic                  mem_req_write_readn;
    logic                  mem_req_phys_func;
    logic [31:0]           mem_req_write_data;
    logic                  mem_req_ready;

    logic                  axi_cpld_valid;
    logic [31:0]           axi_cpld_data;
    logic                  axi_cpld_ready;

    logic [NUM_REQ-1:0]    cpld_valid;
    logic [NUM_REQ-1:0]    cpld_ready;
    logic [31:0]           cpld_data;

    modport master (
        input  req_valid, req_bar_hit, req_pcie_address, req_byte_enable,
               req_write_readn, req_phys_func, req_write_data,
        output req_ready,
        output mem_req_valid, mem_req_bar_hit, mem_req_pcie_address,
               mem_req_byte_enable, mem_req_write_readn, mem_req_phys_func,
               mem_req_write_data,
        input  mem_req_ready,
        input  axi_cpld_valid, axi_cpld_data,
        output axi_cpld_ready,
        output cpld_valid, cpld_data,
        input  cpld_ready
    );

    modport slave (
        output req_valid, req_bar_hit, req_pcie_address, req_byte_enable,
               req_write_readn, req_phys_func, req_write_data,
        input  req_ready,
        input  mem_req_valid, mem_req_bar_hit, mem_req_pcie_address,
               mem_req_byte_enable, mem_req_write_readn, mem_req_phys_func,
               mem_req_write_data,
        output mem_req_ready,
        output axi_cpld_valid, axi_cpld_data,
        input  axi_cpld_ready,
        input  cpld_valid, cpld_data,
        output cpld_ready
    );
endinterface

// File: rtl/maxi_req_arbiter.sv
// Round-robin arbiter that shares the controller's memory-request port.
// Each granted read leaves its requester index in an in-order tag FIFO.
// Returning completions are steered to the requester at the FIFO head.
//
// state | meaning
// IDLE  | arbitrating; a grant captures the winner into the holding stage
// PEND  | holding stage presented on mem_req_*, waiting for mem_req_ready
module maxi_req_arbiter #(
    parameter int NUM_REQ           = 2,
    parameter int OUTSTANDING_READS = 5,
    parameter int IDX_W             = 3
) (
    input  logic                   m_axi_aclk,
    input  logic                   m_axi_aresetn,
    maxi_req_arbiter_if.master     bus,
    output logic [IDX_W:0]         rd_outstanding,
    output logic                   cpld_orphan
);

    localparam int CNT_W = IDX_W + 1;
    localparam int PTR_W = (OUTSTANDING_READS > 1) ? $clog2(OUTSTANDING_READS) : 1;
    localparam logic [CNT_W-1:0] MAX_RD   = CNT_W'(OUTSTANDING_READS);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING_READS - 1);

    typedef enum logic {IDLE, PEND} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q;
    logic [IDX_W-1:0]   winner;
    logic               found;
    logic               grant;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [IDX_W-1:0]   head;
    logic [NUM_REQ-1:0] eligible;

    logic [2:0]         sel_bar_hit;
    logic [31:0]        sel_address;
    logic [3:0]         sel_byte_enable;
    logic               sel_write_readn;
    logic               sel_phys_func;
    logic [31:0]        sel_write_data;

    logic [2:0]         hold_bar_hit;
    logic [31:0]        hold_address;
    logic [3:0]         hold_byte_enable;
    logic               hold_write_readn;
    logic               hold_phys_func;
    logic [31:0]        hold_write_data;

    logic [IDX_W-1:0]   tag_mem [OUTSTANDING_READS];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               orphan_q;

    // Eligibility uses the pre-pop count, so a full FIFO blocks reads only.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req_valid[i] &
                          (bus.req_write_readn[i] | (count_q < MAX_RD));
        end
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int cand;
        cand   = 0;
        found  = 1'b0;
        winner = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_grant_q) + off) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (cand == i) && eligible[i]) begin
                    found  = 1'b1;
                    winner = IDX_W'(i);
                end
            end
        end
    end

    // Select the winner's request fields for capture into the holding stage.
    always_comb begin
        sel_bar_hit     = '0;
        sel_address     = '0;
        sel_byte_enable = '0;
        sel_write_readn = 1'b0;
        sel_phys_func   = 1'b0;
        sel_write_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                sel_bar_hit     = bus.req_bar_hit[3*i +: 3];
                sel_address     = bus.req_pcie_address[32*i +: 32];
                sel_byte_enable = bus.req_byte_enable[4*i +: 4];
                sel_write_readn = bus.req_write_readn[i];
                sel_phys_func   = bus.req_phys_func[i];
                sel_write_data  = bus.req_write_data[32*i +: 32];
            end
        end
    end

    // FSM next state, grant and request-side outputs.
    always_comb begin
        state_d           = state_q;
        grant             = 1'b0;
        bus.req_ready     = '0;
        bus.mem_req_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (found && m_axi_aresetn) begin
                    grant   = 1'b1;
                    state_d = PEND;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (winner == IDX_W'(i)) bus.req_ready[i] = 1'b1;
                    end
                end
            end
            PEND: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign push = grant & ~sel_write_readn;

    // Completion steering from the tag FIFO head; empty FIFO swallows beats.
    always_comb begin
        fifo_empty         = (count_q == '0);
        head               = tag_mem[rd_ptr_q];
        bus.cpld_valid     = '0;
        bus.axi_cpld_ready = 1'b1;
        if (!fifo_empty) begin
            bus.axi_cpld_ready = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (head == IDX_W'(i)) begin
                    bus.cpld_valid[i]  = bus.axi_cpld_valid;
                    bus.axi_cpld_ready = bus.cpld_ready[i];
                end
            end
        end
        pop = bus.axi_cpld_valid & bus.axi_cpld_ready & ~fifo_empty;
    end

    assign bus.cpld_data = bus.axi_cpld_data;

    // FSM state register.
    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) state_q <= IDLE;
        else                state_q <= state_d;
    end

    // Holding stage and round-robin pointer, loaded on every grant.
    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            last_grant_q     <= IDX_W'(NUM_REQ - 1);
            hold_bar_hit     <= '0;
            hold_address     <= '0;
            hold_byte_enable <= '0;
            hold_write_readn <= 1'b0;
            hold_phys_func   <= 1'b0;
            hold_write_data  <= '0;
        end else if (grant) begin
            last_grant_q     <= winner;
            hold_bar_hit     <= sel_bar_hit;
            hold_address     <= sel_address;
            hold_byte_enable <= sel_byte_enable;
            hold_write_readn <= sel_write_readn;
            hold_phys_func   <= sel_phys_func;
            hold_write_data  <= sel_write_data;
        end
    end

    // Tag FIFO pointers, occupancy and sticky orphan flag.
    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (bus.axi_cpld_valid && fifo_empty) orphan_q <= 1'b1;
        end
    end

    // Tag storage; contents are only meaningful between the pointers.
    always_ff @(posedge m_axi_aclk) begin
        if (push) tag_mem[wr_ptr_q] <= winner;
    end

    assign bus.mem_req_bar_hit      = hold_bar_hit;
    assign bus.mem_req_pcie_address = hold_address;
    assign bus.mem_req_byte_enable  = hold_byte_enable;
    assign bus.mem_req_write_readn  = hold_write_readn;
    assign bus.mem_req_phys_func    = hold_phys_func;
    assign bus.mem_req_write_data   = hold_write_data;
    assign rd_outstanding           = count_q;
    assign cpld_orphan              = orphan_q;

endmodule
